// File: rtl/ppu_sched_if.sv
// ppu_sched_if: bundles the job-configuration, accumulator-buffer and ppu
// control signals of the post-processing-unit job sequencer.
//   slave  modport : used by ppu_sched (takes i_* inputs, drives o_* outputs)
//   master modport : used by the surrounding environment
// Signals:
//   i_cfg_valid/o_cfg_ready, i_cfg_mode, i_cfg_relu_en : job request handshake
//   i_tiles_avail                                      : tiles committed to buffer
//   o_buf_re, o_buf_addr                               : buffer read port
//   o_ppu_start, o_ppu_mode, o_ppu_relu_en             : ppu control
//   i_ppu_finish                                       : quantizer finish pulse
//   o_pass, o_tile_idx, o_busy, o_done                 : status
interface ppu_sched_if #(
    parameter int NUM_TILES = 4,
    parameter int ADDR_W    = $clog2(NUM_TILES * 16),
    parameter int CNT_W     = $clog2(NUM_TILES + 1)
);
    logic              i_cfg_valid;
    logic              o_cfg_ready;
    logic [1:0]        i_cfg_mode;
    logic              i_cfg_relu_en;
    logic [CNT_W-1:0]  i_tiles_avail;
    logic              o_buf_re;
    logic [ADDR_W-1:0] o_buf_addr;
    logic              o_ppu_start;
    logic [1:0]        o_ppu_mode;
    logic              o_ppu_relu_en;
    logic              i_ppu_finish;
    logic              o_pass;
    logic [CNT_W-1:0]  o_tile_idx;
    logic              o_busy;
    logic              o_done;

    modport slave (
        input  i_cfg_valid, i_cfg_mode, i_cfg_relu_en, i_tiles_avail, i_ppu_finish,
        output o_cfg_ready, o_buf_re, o_buf_addr, o_ppu_start, o_ppu_mode,
               o_ppu_relu_en, o_pass, o_tile_idx, o_busy, o_done
    );

    modport master (
        output i_cfg_valid, i_cfg_mode, i_cfg_relu_en, i_tiles_avail, i_ppu_finish,
        input  o_cfg_ready, o_buf_re, o_buf_addr, o_ppu_start, o_ppu_mode,
               o_ppu_relu_en, o_pass, o_tile_idx, o_busy, o_done
    );
endinterface

// File: rtl/ppu_sched.sv
// ppu_sched: job-level sequencer for the post-processing unit.
// Accepts one job (mode, ReLU), streams 16-row accumulator tiles from the
// tile buffer into the ppu as they become available, runs a max pass then a
// calc pass for non-VSQ modes (calc pass only for VSQ), then waits for the
// quantizer finish pulse and raises a one-cycle done.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : ppu_sched_if.slave (config handshake, buffer read, ppu control, status)
//
// state    | meaning
// S_IDLE   | ready for a job
// S_WAIT   | waiting for the current tile to be committed
// S_ISSUE  | ppu start pulse, read row 0
// S_STREAM | read rows 1..15
// S_GAP    | ppu consumes row 15, advance tile/pass
// S_FIN    | waiting for quantizer finish
// S_DONE   | one-cycle done pulse
module ppu_sched #(
    parameter int         NUM_TILES     = 4,
    parameter int         ADDR_W        = $clog2(NUM_TILES * 16),
    parameter int         CNT_W         = $clog2(NUM_TILES + 1),
    parameter logic [1:0] MODE_INT4_VSQ = 2'd3
) (
    input logic       i_clk,
    input logic       i_rst_n,
    ppu_sched_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(NUM_TILES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] tile;
    logic [3:0]       row;
    logic             pass;
    logic             resident;   // max pass complete: every tile is in the buffer
    logic             fin_seen;   // finish arrived early, during the last calc tile
    logic [1:0]       mode;
    logic             relu_en;

    logic             last_calc_tile;
    logic [ADDR_W-1:0] tile_base;

    assign last_calc_tile = pass && (tile == LAST_TILE);
    assign tile_base      = ADDR_W'(tile) << 4;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            tile     <= '0;
            row      <= '0;
            pass     <= 1'b0;
            resident <= 1'b0;
            fin_seen <= 1'b0;
            mode     <= 2'd0;
            relu_en  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_cfg_valid) begin
                        mode     <= bus.i_cfg_mode;
                        relu_en  <= bus.i_cfg_relu_en;
                        pass     <= (bus.i_cfg_mode == MODE_INT4_VSQ);
                        tile     <= '0;
                        row      <= '0;
                        resident <= 1'b0;
                        fin_seen <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // tile never exceeds NUM_TILES-1, so an over-range
                    // availability count behaves as NUM_TILES here.
                    if (resident || (tile < bus.i_tiles_avail)) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    row   <= 4'd1;
                    state <= S_STREAM;
                    if (last_calc_tile && bus.i_ppu_finish) fin_seen <= 1'b1;
                end
                S_STREAM: begin
                    if (last_calc_tile && bus.i_ppu_finish) fin_seen <= 1'b1;
                    if (row == 4'd15) begin
                        state <= S_GAP;
                    end else begin
                        row <= row + 4'd1;
                    end
                end
                S_GAP: begin
                    row <= 4'd0;
                    if (last_calc_tile && bus.i_ppu_finish) fin_seen <= 1'b1;
                    if (tile == LAST_TILE) begin
                        if (!pass) begin
                            pass     <= 1'b1;
                            tile     <= '0;
                            resident <= 1'b1;
                            state    <= S_WAIT;
                        end else begin
                            state <= S_FIN;
                        end
                    end else begin
                        tile  <= tile + CNT_W'(1);
                        state <= S_WAIT;
                    end
                end
                S_FIN: begin
                    if (bus.i_ppu_finish || fin_seen) state <= S_DONE;
                end
                S_DONE: begin
                    fin_seen <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_cfg_ready   = (state == S_IDLE);
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_buf_re      = (state == S_ISSUE) || (state == S_STREAM);
    assign bus.o_buf_addr    = tile_base | ADDR_W'(row);
    assign bus.o_ppu_start   = (state == S_ISSUE);
    assign bus.o_done        = (state == S_DONE);
    assign bus.o_ppu_mode    = mode;
    assign bus.o_ppu_relu_en = relu_en;
    assign bus.o_pass        = pass;
    assign bus.o_tile_idx    = tile;
endmodule
